// File: rtl/soc_system_limits_dbuf.sv
// Double-buffered limits table: CPU fills the shadow bank over s1, fabric reads the
// active bank over s2, and a commit swaps banks with an optional shadow refresh copy.
module soc_system_limits_dbuf #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH/8-1:0] byteenable,
   input  logic                    read,
   input  logic                    write,
   input  logic [DATA_WIDTH-1:0]   writedata,
   output logic [DATA_WIDTH-1:0]   readdata,
   output logic                    readdatavalid,
   output logic                    waitrequest,
   input  logic [1:0]              csr_address,
   input  logic                    csr_read,
   input  logic                    csr_write,
   input  logic [31:0]             csr_writedata,
   output logic [31:0]             csr_readdata,
   input  logic [ADDR_WIDTH-1:0]   address2,
   input  logic                    read2,
   output logic [DATA_WIDTH-1:0]   readdata2,
   output logic                    readdatavalid2,
   input  logic                    frame_sync
);

   localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
   localparam int unsigned MEM_WORDS = 2 ** (ADDR_WIDTH + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   typedef enum logic {S_IDLE, S_COPY} state_t;

   // Both banks in one array, bank select is the top index bit.
   logic [DATA_WIDTH-1:0] r_mem [0:MEM_WORDS-1];

   state_t                r_state;
   logic                  r_active;
   logic                  r_pending;
   logic                  r_auto_copy;
   logic                  r_immediate;
   logic [CNT_WIDTH-1:0]  r_swap_count;
   logic                  r_waitrequest;
   logic [DATA_WIDTH-1:0] r_readdata;
   logic                  r_readdatavalid;
   logic [DATA_WIDTH-1:0] r_readdata2;
   logic                  r_readdatavalid2;
   logic [31:0]           r_csr_readdata;

   logic [ADDR_WIDTH-1:0] r_copy_ptr;
   logic                  r_cp_rd_done;
   logic                  r_cp_wvalid;
   logic [ADDR_WIDTH-1:0] r_cp_waddr;
   logic [DATA_WIDTH-1:0] r_cp_data;

   logic                  w_busy;
   logic                  w_s1_wr;
   logic                  w_s1_rd;
   logic [ADDR_WIDTH:0]   w_shadow_idx;
   logic [ADDR_WIDTH:0]   w_active_idx2;
   logic                  w_copy_rd;
   logic                  w_ctrl_wr;
   logic                  w_commit;
   logic                  w_swap;
   logic                  w_unused;

   assign w_busy        = (r_state == S_COPY);
   assign w_s1_wr       = write & ~w_busy & ~reset;
   assign w_s1_rd       = read & ~write & ~w_busy;
   assign w_shadow_idx  = {~r_active, address};
   assign w_active_idx2 = {r_active, address2};
   // s2 owns the active-bank read port; the copy only steps on idle cycles.
   assign w_copy_rd     = w_busy & ~read2 & ~r_cp_rd_done;
   assign w_ctrl_wr     = csr_write & (csr_address == 2'd0);
   assign w_commit      = w_ctrl_wr & csr_writedata[0];
   assign w_swap        = ~w_busy & r_pending & (r_immediate | frame_sync);
   assign w_unused      = &{1'b0, csr_writedata[31:3]};

   assign readdata       = r_readdata;
   assign readdatavalid  = r_readdatavalid;
   assign waitrequest    = r_waitrequest;
   assign csr_readdata   = r_csr_readdata;
   assign readdata2      = r_readdata2;
   assign readdatavalid2 = r_readdatavalid2;

   // Shadow-bank writes: copy engine while busy, s1 otherwise (never both).
   always_ff @(posedge clk) begin
      if (r_cp_wvalid) begin
         r_mem[{~r_active, r_cp_waddr}] <= r_cp_data;
      end else if (w_s1_wr) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            if (byteenable[b]) begin
               r_mem[w_shadow_idx][b*8 +: 8] <= writedata[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state          <= S_IDLE;
         r_active         <= 1'b0;
         r_pending        <= 1'b0;
         r_auto_copy      <= 1'b0;
         r_immediate      <= 1'b0;
         r_swap_count     <= '0;
         r_waitrequest    <= 1'b0;
         r_readdata       <= '0;
         r_readdatavalid  <= 1'b0;
         r_readdata2      <= '0;
         r_readdatavalid2 <= 1'b0;
         r_csr_readdata   <= '0;
         r_copy_ptr       <= '0;
         r_cp_rd_done     <= 1'b0;
         r_cp_wvalid      <= 1'b0;
         r_cp_waddr       <= '0;
         r_cp_data        <= '0;
      end else begin
         r_readdatavalid <= w_s1_rd;
         if (w_s1_rd) begin
            r_readdata <= r_mem[w_shadow_idx];
         end

         r_readdatavalid2 <= read2;
         if (read2) begin
            r_readdata2 <= r_mem[w_active_idx2];
         end

         if (csr_read) begin
            case (csr_address)
               2'd0:    r_csr_readdata <= {29'd0, r_immediate, r_auto_copy, 1'b0};
               2'd1:    r_csr_readdata <= {29'd0, r_active, w_busy, r_pending};
               2'd2:    r_csr_readdata <= 32'(r_swap_count);
               default: r_csr_readdata <= 32'd0;
            endcase
         end

         if (w_ctrl_wr) begin
            r_auto_copy <= csr_writedata[1];
            r_immediate <= csr_writedata[2];
         end

         // A swap consumes the pending flag, so a commit in that cycle is absorbed.
         if (w_swap) begin
            r_pending <= 1'b0;
         end else if (w_commit) begin
            r_pending <= 1'b1;
         end

         // Copy read stage; the captured word is written to the shadow next cycle.
         r_cp_wvalid <= w_copy_rd;
         if (w_copy_rd) begin
            r_cp_data  <= r_mem[{r_active, r_copy_ptr}];
            r_cp_waddr <= r_copy_ptr;
            r_copy_ptr <= r_copy_ptr + ADDR_WIDTH'(1);
            if (r_copy_ptr == LAST_ADDR) begin
               r_cp_rd_done <= 1'b1;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (w_swap) begin
                  r_active     <= ~r_active;
                  r_swap_count <= r_swap_count + CNT_WIDTH'(1);
                  if (r_auto_copy) begin
                     r_state       <= S_COPY;
                     r_waitrequest <= 1'b1;
                     r_copy_ptr    <= '0;
                     r_cp_rd_done  <= 1'b0;
                  end
               end
            end
            S_COPY: begin
               if (r_cp_wvalid && (r_cp_waddr == LAST_ADDR)) begin
                  r_state       <= S_IDLE;
                  r_waitrequest <= 1'b0;
               end
            end
            default: begin
               r_state       <= S_IDLE;
               r_waitrequest <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_soc_system_limits_dbuf.sv
// Self-checking bench: directed scenarios plus random traffic, checked every cycle
// against a bank-array reference model of the double-buffered limits table.
module tb_soc_system_limits_dbuf;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 4;
   localparam int unsigned CW = 4;
   localparam int unsigned DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] address = '0;
   logic [3:0]    byteenable = '0;
   logic          read = 1'b0;
   logic          write = 1'b0;
   logic [DW-1:0] writedata = '0;
   logic [DW-1:0] readdata;
   logic          readdatavalid;
   logic          waitrequest;
   logic [1:0]    csr_address = '0;
   logic          csr_read = 1'b0;
   logic          csr_write = 1'b0;
   logic [31:0]   csr_writedata = '0;
   logic [31:0]   csr_readdata;
   logic [AW-1:0] address2 = '0;
   logic          read2 = 1'b0;
   logic [DW-1:0] readdata2;
   logic          readdatavalid2;
   logic          frame_sync = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   soc_system_limits_dbuf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .address(address), .byteenable(byteenable), .read(read), .write(write),
      .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
      .waitrequest(waitrequest),
      .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
      .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
      .address2(address2), .read2(read2), .readdata2(readdata2),
      .readdatavalid2(readdatavalid2), .frame_sync(frame_sync)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_bank [2][DEPTH];
   bit          m_active, m_pending, m_auto, m_imm, m_busy;
   logic [CW-1:0] m_count;
   int          m_issued;
   bit          m_wv;
   int          m_widx;
   logic [31:0] m_wdata;
   logic [31:0] e_rd, e_rd2, e_csr;
   bit          e_rdv, e_rdv2, e_csr_v, e_wait, e_rst;

   always @(posedge clk) begin : model
      bit old_act, busy0, swap, commit, done;
      int sh, ac;
      if (reset) begin
         m_active = 0; m_pending = 0; m_auto = 0; m_imm = 0; m_busy = 0;
         m_count = '0; m_issued = 0; m_wv = 0;
         e_rdv = 0; e_rdv2 = 0; e_csr_v = 0; e_wait = 0; e_rst = 1;
      end else begin
         e_rst   = 0;
         old_act = m_active;
         busy0   = m_busy;
         sh      = old_act ? 0 : 1;
         ac      = old_act ? 1 : 0;
         e_rdv   = 0;
         if (!busy0 && write) begin
            for (int b = 0; b < 4; b++)
               if (byteenable[b]) m_bank[sh][address][b*8 +: 8] = writedata[b*8 +: 8];
         end else if (!busy0 && read) begin
            e_rd  = m_bank[sh][address];
            e_rdv = 1;
         end
         e_rdv2 = read2;
         if (read2) e_rd2 = m_bank[ac][address2];
         e_csr_v = csr_read;
         if (csr_read) begin
            case (csr_address)
               2'd0:    e_csr = (m_auto ? 32'd2 : 32'd0) + (m_imm ? 32'd4 : 32'd0);
               2'd1:    e_csr = (m_pending ? 32'd1 : 32'd0) + (busy0 ? 32'd2 : 32'd0)
                                + (old_act ? 32'd4 : 32'd0);
               2'd2:    e_csr = 32'(m_count);
               default: e_csr = 32'd0;
            endcase
         end
         if (busy0) begin
            done = 0;
            if (m_wv) begin
               m_bank[sh][m_widx] = m_wdata;
               m_wv = 0;
               done = (m_widx == DEPTH - 1);
            end
            if (!read2 && m_issued < DEPTH) begin
               m_wv = 1; m_widx = m_issued; m_wdata = m_bank[ac][m_issued];
               m_issued++;
            end
            if (done) m_busy = 0;
         end
         swap   = !busy0 && m_pending && (m_imm || frame_sync);
         commit = csr_write && csr_address == 2'd0 && csr_writedata[0];
         if (swap) begin
            m_active  = !m_active;
            m_count   = m_count + 1'b1;
            m_pending = 0;
            if (m_auto) begin m_busy = 1; m_issued = 0; m_wv = 0; end
         end else if (commit) begin
            m_pending = 1;
         end
         if (csr_write && csr_address == 2'd0) begin
            m_auto = csr_writedata[1];
            m_imm  = csr_writedata[2];
         end
         e_wait = m_busy;
      end
   end

   // ---------------- per-cycle compare ----------------
   always begin
      @(posedge clk);
      #2;
      if (e_rst) begin
         check("rst_readdata", readdata, 32'd0);
         check("rst_readdatavalid", 32'(readdatavalid), 32'd0);
         check("rst_readdata2", readdata2, 32'd0);
         check("rst_readdatavalid2", 32'(readdatavalid2), 32'd0);
         check("rst_csr_readdata", csr_readdata, 32'd0);
         check("rst_waitrequest", 32'(waitrequest), 32'd0);
      end else begin
         check("waitrequest", 32'(waitrequest), 32'(e_wait));
         check("readdatavalid", 32'(readdatavalid), 32'(e_rdv));
         if (e_rdv) check("readdata", readdata, e_rd);
         check("readdatavalid2", 32'(readdatavalid2), 32'(e_rdv2));
         if (e_rdv2) check("readdata2", readdata2, e_rd2);
         if (e_csr_v) check("csr_readdata", csr_readdata, e_csr);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (waitrequest && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) check("waitrequest_timeout", 32'(waitrequest), 32'd0);
   endtask

   task automatic s1_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
      write = 1; address = a; writedata = d; byteenable = be;
      wait_ready();
      @(negedge clk);
      write = 0; byteenable = '0;
   endtask

   task automatic s1_read(input logic [AW-1:0] a, output logic [31:0] d);
      read = 1; address = a;
      wait_ready();
      @(negedge clk);
      read = 0;
      d = readdata;
   endtask

   task automatic s2_read(input logic [AW-1:0] a, output logic [31:0] d);
      read2 = 1; address2 = a;
      @(negedge clk);
      read2 = 0;
      d = readdata2;
   endtask

   task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
      csr_write = 1; csr_address = a; csr_writedata = d;
      @(negedge clk);
      csr_write = 0;
   endtask

   task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
      csr_read = 1; csr_address = a;
      @(negedge clk);
      csr_read = 0;
      d = csr_readdata;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- directed and random scenarios ----------------
   initial begin
      logic [31:0] d, d_old, d_new, c0;
      int busy_cnt;

      tick(3);
      reset = 0;
      tick(1);
      check("rst_wait_lit", 32'(waitrequest), 32'd0);
      csr_rd(2'd1, d); check("rst_status_lit", d, 32'h0);
      csr_rd(2'd2, d); check("rst_count_lit", d, 32'h0);

      // immediate commit makes addr 5 visible on s2
      s1_write(4'd5, 32'hDEADBEEF, 4'hF);
      csr_wr(2'd0, 32'h5);
      tick(2);
      csr_rd(2'd1, d); check("imm_status_lit", d, 32'h4);
      csr_rd(2'd2, d); check("imm_count_lit", d, 32'h1);
      s2_read(4'd5, d); check("imm_s2_lit", d, 32'hDEADBEEF);

      // fill both banks so every later read has a known value
      for (int i = 0; i < DEPTH; i++) s1_write(AW'(i), $urandom, 4'hF);
      csr_wr(2'd0, 32'h5);
      tick(2);
      for (int i = 0; i < DEPTH; i++) s1_write(AW'(i), $urandom, 4'hF);

      // byte-lane merge
      s1_write(4'd7, 32'h11223344, 4'hF);
      s1_write(4'd7, 32'hAABBCCDD, 4'b0010);
      s1_read(4'd7, d); check("byteen_lit", d, 32'h1122CC44);

      // frame-synchronised swap
      csr_wr(2'd0, 32'h0);
      s1_write(4'd2, 32'h5A5A0001, 4'hF);
      csr_wr(2'd0, 32'h1);
      csr_rd(2'd1, d); check("fs_pending_lit", d, 32'h1);
      tick(3);
      csr_rd(2'd1, d); check("fs_pending_hold_lit", d, 32'h1);
      frame_sync = 1; read2 = 1; address2 = 4'd2;
      @(negedge clk);
      frame_sync = 0;
      d_old = readdata2;
      @(negedge clk);
      read2 = 0;
      d_new = readdata2;
      check("fs_old_data", d_old, m_bank[0][2]);
      check("fs_new_lit", d_new, 32'h5A5A0001);
      csr_rd(2'd1, d); check("fs_status_lit", d, 32'h4);

      // auto-copy with s2 contention and a held s1 read
      csr_wr(2'd0, 32'h6);
      s1_write(4'd3, 32'hC0FFEE03, 4'hF);
      csr_wr(2'd0, 32'h7);
      busy_cnt = 0;
      fork
         begin
            for (int i = 0; i < 70; i++) begin
               read2 = i[0]; address2 = AW'($urandom_range(15));
               @(negedge clk);
            end
            read2 = 0;
         end
         begin
            for (int i = 0; i < 80; i++) begin
               if (waitrequest) busy_cnt++;
               @(negedge clk);
            end
         end
         begin
            tick(3);
            s1_read(4'd3, d);
            check("copy_held_read_lit", d, 32'hC0FFEE03);
         end
      join
      check("copy_busy_ge16", 32'(busy_cnt >= 16), 32'd1);

      // commits and frame_sync during COPY yield exactly one more swap
      csr_wr(2'd0, 32'h7);
      tick(2);
      csr_rd(2'd2, c0); check("copy_count0_lit", c0, 32'd5);
      csr_wr(2'd0, 32'h7);
      tick(2);
      csr_wr(2'd0, 32'h7);
      frame_sync = 1; tick(1); frame_sync = 0;
      wait_ready();
      tick(3);
      wait_ready();
      csr_wr(2'd0, 32'h0);
      tick(2);
      csr_rd(2'd2, d); check("copy_count1_lit", d, 32'd6);
      csr_rd(2'd1, d); check("copy_status_lit", d, 32'h0);

      // reset in the middle of a copy
      csr_wr(2'd0, 32'h7);
      tick(5);
      check("pre_rst_busy_lit", 32'(waitrequest), 32'd1);
      reset = 1; tick(2); reset = 0; tick(1);
      check("post_rst_wait_lit", 32'(waitrequest), 32'd0);
      csr_rd(2'd1, d); check("post_rst_status_lit", d, 32'h0);
      csr_rd(2'd2, d); check("post_rst_count_lit", d, 32'h0);
      csr_rd(2'd0, d); check("post_rst_ctrl_lit", d, 32'h0);
      s1_write(4'd9, 32'h12345678, 4'hF);
      s1_read(4'd9, d); check("post_rst_s1_lit", d, 32'h12345678);
      s2_read(4'd9, d);

      // random traffic, model-checked every cycle
      for (int i = 0; i < 1500; i++) begin
         write         = ($urandom_range(3) == 0);
         read          = ($urandom_range(2) == 0);
         address       = AW'($urandom_range(15));
         byteenable    = 4'($urandom);
         writedata     = $urandom;
         read2         = $urandom_range(1) == 1;
         address2      = AW'($urandom_range(15));
         frame_sync    = ($urandom_range(7) == 0);
         csr_write     = ($urandom_range(4) == 0);
         csr_address   = ($urandom_range(9) < 7) ? 2'd0 : 2'($urandom_range(3));
         csr_writedata = 32'($urandom_range(7));
         csr_read      = ($urandom_range(2) == 0);
         if (csr_read && !csr_write) csr_address = 2'($urandom_range(3));
         @(negedge clk);
      end
      write = 0; read = 0; read2 = 0; frame_sync = 0; csr_write = 0; csr_read = 0;
      csr_wr(2'd0, 32'h0);
      tick(2);
      wait_ready();
      tick(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
